// File: rtl/bit_stuffer_p.sv
// bit_stuffer_p
//   Parametrised bit stuffer between the CRC stage and the NRZI encoder.
//   The first SKIP_BITS bits of each packet (the PID) pass through untouched.
//   After that, one ~RUN_BIT is inserted after every RUN_LEN consecutive
//   RUN_BIT values. This includes a run that completes on the last packet bit.
//
// Parameters
//   RUN_LEN    run length that triggers a stuff (1..255)
//   RUN_BIT    bit value being counted; the stuffed bit is ~RUN_BIT
//   SKIP_BITS  leading bits never counted or stuffed (0 disables skipping)
//   CNT_W      width of stuff_count
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     high for the whole packet; first low after acceptance ends it
//   in_bit       serial data, transferred when in_valid && in_ready
//   in_ready     combinational, low only while a stuff bit is being emitted
//   out_valid    registered, an output bit is present
//   out_bit      registered output bit
//   stuffing     registered, out_bit is a stuff bit
//   stuff_count  stuffs inserted in the current/last packet, saturating
module bit_stuffer_p #(
  parameter int   RUN_LEN   = 6,
  parameter logic RUN_BIT   = 1'b1,
  parameter int   SKIP_BITS = 8,
  parameter int   CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic             stuffing,
  output logic [CNT_W-1:0] stuff_count
);

  localparam int SKIP_W = (SKIP_BITS < 2) ? 1 : $clog2(SKIP_BITS + 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_BITS - 1);
  localparam logic [7:0]        RUN_LAST  = 8'(RUN_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_COUNT = 2'd2,
    ST_STUFF = 2'd3
  } state_t;

  state_t              state;
  logic [7:0]          run_cnt;
  logic [SKIP_W-1:0]   skip_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The source must hold its bit while the stuff bit occupies the output.
  assign in_ready = (state != ST_STUFF);

  // Input bit accepted -> registered output bit, one cycle of latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      run_cnt     <= '0;
      skip_cnt    <= '0;
      out_valid   <= 1'b0;
      out_bit     <= 1'b0;
      stuffing    <= 1'b0;
      stuff_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          stuffing <= 1'b0;
          if (in_valid) begin
            out_valid   <= 1'b1;
            out_bit     <= in_bit;
            stuff_count <= '0;
            skip_cnt    <= SKIP_W'(1);
            run_cnt     <= '0;
            if (SKIP_BITS > 1) begin
              state <= ST_SKIP;
            end else if (SKIP_BITS == 1) begin
              state <= ST_COUNT;
            end else if (in_bit == RUN_BIT) begin
              // No PID: this first bit already counts toward a run.
              if (RUN_LAST == 8'd0) begin
                state <= ST_STUFF;
              end else begin
                run_cnt <= 8'd1;
                state   <= ST_COUNT;
              end
            end else begin
              state <= ST_COUNT;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end

        ST_SKIP: begin
          stuffing <= 1'b0;
          if (in_valid) begin
            out_valid <= 1'b1;
            out_bit   <= in_bit;
            skip_cnt  <= skip_cnt + SKIP_W'(1);
            if (skip_cnt == SKIP_LAST) begin
              run_cnt <= '0;
              state   <= ST_COUNT;
            end
          end else begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_COUNT: begin
          stuffing <= 1'b0;
          if (in_valid) begin
            out_valid <= 1'b1;
            out_bit   <= in_bit;
            if (in_bit == RUN_BIT) begin
              if (run_cnt == RUN_LAST) begin
                run_cnt <= '0;
                state   <= ST_STUFF;
              end else begin
                run_cnt <= run_cnt + 8'd1;
              end
            end else begin
              run_cnt <= '0;
            end
          end else begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_STUFF: begin
          // The trailing stuff bit is emitted even if the packet just ended.
          out_valid   <= 1'b1;
          out_bit     <= ~RUN_BIT;
          stuffing    <= 1'b1;
          stuff_count <= sat_inc(stuff_count);
          run_cnt     <= '0;
          state       <= in_valid ? ST_COUNT : ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_stuffer_p.md
Name: bit_stuffer_p

Overview:
- Parametrised successor to the team's fixed USB bit stuffer.
- Accepts a serial packet bitstream from the CRC stage on a valid/ready handshake and passes the first SKIP_BITS bits (PID field) unmodified.
- Afterwards, inserts one ~RUN_BIT after every RUN_LEN consecutive RUN_BIT values, including a run that completes on the last bit of the packet.
- Output is registered and feeds the NRZI encoder; a per-packet stuffed-bit count is exported for debug/verification.

Parameters:
- RUN_LEN, 6, number of consecutive RUN_BIT values that triggers a stuff; legal range 1..255.
- RUN_BIT, 1'b1, bit value being counted; the stuffed bit is ~RUN_BIT.
- SKIP_BITS, 8, leading bits of each packet that are never counted or stuffed; 0 disables skipping.
- CNT_W, 8, width of stuff_count.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  high for the whole packet; the first 0 after acceptance marks end of packet.
- in_bit  input  1  data bit; transferred when in_valid && in_ready.
- in_ready  output  1  combinational; low only in the STUFF state.
- out_valid  output  1  registered; an output bit is present this cycle.
- out_bit  output  1  registered output bit.
- stuffing  output  1  registered; high while out_bit is a stuff bit.
- stuff_count  output  CNT_W  stuffs inserted in the current/last packet; saturates at all-ones.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports named clock and reset.
- Reset values:
  - out_valid=0, out_bit=0, stuffing=0, stuff_count=0.
  - State=IDLE, run_cnt=0, skip_cnt=0.
  - in_ready=1.
- Latency: an accepted bit appears on out_bit exactly 1 cycle later with out_valid=1. A stuff bit occupies one extra output cycle; every later bit shifts by 1.
- IDLE:
  - out_valid=0.
  - If in_valid: accept the bit, clear run_cnt and stuff_count, set skip_cnt=1.
  - Go to SKIP if SKIP_BITS>1; otherwise go to COUNT, processing that bit as in COUNT when SKIP_BITS==0.
- SKIP:
  - Accept bits; skip_cnt increments; no counting.
  - When the SKIP_BITS-th bit is accepted, go to COUNT with run_cnt=0.
  - If in_valid drops, go to IDLE.
- COUNT, on an accepted bit b:
  - If b==RUN_BIT and run_cnt==RUN_LEN-1: run_cnt<=0 and go to STUFF.
  - Else if b==RUN_BIT: run_cnt+1.
  - Else: run_cnt<=0.
  - If in_valid==0: go to IDLE; out_valid drops on the next cycle.
- STUFF (single cycle):
  - in_ready=0; out_bit<=~RUN_BIT, stuffing<=1, out_valid<=1, stuff_count +1 (saturating).
  - Next state is COUNT if in_valid, else IDLE.
  - The source must hold in_bit/in_valid while in_ready=0. in_valid dropping during STUFF ends the packet and the trailing stuff bit is still emitted.
- The stuff bit restarts counting (run_cnt=0).
- Back-to-back packets: in_valid low for ≥1 cycle separates packets. A new packet starting in the cycle after an end is accepted from IDLE normally.
- RUN_LEN==1: every RUN_BIT is followed by a stuff bit, and no two consecutive input bits are accepted when both equal RUN_BIT.
- Reset asserted mid-packet: all state and outputs return to reset values immediately; the partial packet is discarded.
- stuff_count holds its value after end of packet until the next packet start.

Test Plan:
- Defaults, 8-bit PID 0xFF followed by 6 ones then 0 -> PID passes unstuffed. Output is the PID, 111111, 0 (stuffing=1), 0; stuff_count=1; in_ready low exactly 1 cycle.
- Defaults, payload of 12 consecutive ones ending the packet -> stuffs after the 6th and 12th one. Trailing stuff bit is emitted after in_valid drops; out_valid lasts 8+14 cycles; stuff_count=2.
- Defaults, payload 111110 repeated -> no stuffing; run_cnt clears on each 0; out_bit equals in_bit delayed 1 cycle.
- RUN_LEN=3, RUN_BIT=0, SKIP_BITS=0, input 000000 -> output 000 1 000 1; stuff_count=2.
- CNT_W=2, 5 stuffs in one packet -> stuff_count saturates at 3.
- Reset pulsed during STUFF -> out_valid, stuffing, stuff_count read 0 the same cycle. The next packet is processed from IDLE with the skip applied again.
